uart_tx_cfg: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_cfg_if.sv | 23 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_cfg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity codes, the transmitter
// state encoding and the clocks-per-bit calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } txState_t;

  // Rounded clocks per bit; the rounding keeps the baud error under half a clock.
  function automatic int calcDiv(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/status bundle between an on-chip producer (master) and the UART
// transmitter (slave), including the serial line itself.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 TxD_start;
  logic [DATA_BITS-1:0] TxD_data;
  logic                 TxD;
  logic                 TxD_busy;
  logic                 TxD_idle;

  modport master (
    output TxD_start, TxD_data,
    input  TxD, TxD_busy, TxD_idle
  );

  modport slave (
    input  TxD_start, TxD_data,
    output TxD, TxD_busy, TxD_idle
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time generator: counts 0..DIV-1 and flags the last clock of each bit.
// A synchronous restart re-aligns the bit grid to a frame start.
module uart_baud_gen import uart_pkg::*; #(
  parameter int FREQ = 50000000,
  parameter int BAUD = 115200,
  localparam int DIV = calcDiv(FREQ, BAUD),
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  assign tick = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// Define UART_TX_FIFO_EN to queue requests in a FIFO_DEPTH-entry FIFO.
module uart_tx_cfg import uart_pkg::*; #(
  parameter int FREQ       = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK50MHZ,
  input  logic          RST_N,
  uart_tx_cfg_if.slave  txIf
);

  localparam int DIV   = calcDiv(FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = 4;

  txState_t             state, stateNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [BIT_W-1:0]     bitCnt, bitCntNext;
  logic                 txdReg, txdNext;
  logic                 parityReg, parityNext;
  logic                 accept;
  logic [DATA_BITS-1:0] loadData;
  logic                 bitEnd;
  logic                 queueEmpty;
  logic                 queueFull;

  // Bit phase is only consumed by the receiver's mid-bit sampling.
  logic [CNT_W-1:0]     baudPhaseUnused;

  uart_baud_gen #(
    .FREQ (FREQ),
    .BAUD (BAUD)
  ) baudGen (
    .clock   (CLK50MHZ),
    .resetN  (RST_N),
    .restart (accept),
    .count   (baudPhaseUnused),
    .tick    (bitEnd)
  );

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W:0]       wrPtr, rdPtr;
  logic                 push, pop;

  // Extra wrap bit separates full from empty when the index bits match.
  assign queueEmpty = (wrPtr == rdPtr);
  assign queueFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                      (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign pop        = (state == S_IDLE) && !queueEmpty;
  assign push       = txIf.TxD_start && (!queueFull || pop);
  assign accept     = pop;
  assign loadData   = fifoMem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge CLK50MHZ) begin
    if (push) begin
      fifoMem[wrPtr[PTR_W-1:0]] <= txIf.TxD_data;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  assign txIf.TxD_busy = queueFull;
`else
  // Queue depth only matters when the FIFO is built.
  logic [$clog2(FIFO_DEPTH):0] fifoDepthUnused;
  assign fifoDepthUnused = '0;

  assign queueEmpty    = 1'b1;
  assign queueFull     = 1'b0;
  assign accept        = txIf.TxD_start && (state == S_IDLE);
  assign loadData      = txIf.TxD_data;
  assign txIf.TxD_busy = (state != S_IDLE) || queueFull;
`endif

  assign txIf.TxD      = txdReg;
  assign txIf.TxD_idle = (state == S_IDLE) && queueEmpty;

  // Next line level is decided here so TxD is a flop and moves on the deciding edge.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    txdNext    = txdReg;
    parityNext = parityReg;
    case (state)
      S_IDLE: begin
        txdNext = 1'b1;
        if (accept) begin
          stateNext  = S_START;
          txdNext    = 1'b0;
          shiftNext  = loadData;
          bitCntNext = '0;
          parityNext = (PARITY == PAR_ODD) ? ~(^loadData) : (^loadData);
        end
      end
      S_START: begin
        if (bitEnd) begin
          stateNext  = S_DATA;
          txdNext    = shiftReg[0];
          shiftNext  = shiftReg >> 1;
          bitCntNext = '0;
        end
      end
      S_DATA: begin
        if (bitEnd) begin
          if (bitCnt == BIT_W'(DATA_BITS - 1)) begin
            bitCntNext = '0;
            if (PARITY != PAR_NONE) begin
              stateNext = S_PARITY;
              txdNext   = parityReg;
            end else begin
              stateNext = S_STOP;
              txdNext   = 1'b1;
            end
          end else begin
            bitCntNext = bitCnt + 1'b1;
            txdNext    = shiftReg[0];
            shiftNext  = shiftReg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bitEnd) begin
          stateNext  = S_STOP;
          txdNext    = 1'b1;
          bitCntNext = '0;
        end
      end
      S_STOP: begin
        if (bitEnd) begin
          if (bitCnt == BIT_W'(STOP_BITS - 1)) begin
            stateNext = S_IDLE;
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      default: begin
        stateNext = S_IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      txdReg    <= 1'b1;
      parityReg <= 1'b0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      txdReg    <= txdNext;
      parityReg <= parityNext;
    end
  end

endmodule
